// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC slot arbiter.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;

    // Channel encoding follows iLRCK: high is the left slot.
    localparam logic CH_L = 1'b1;
    localparam logic CH_R = 1'b0;

    // Bit counter saturates well past the 16 data bits of a slot.
    localparam int BITCNT_W = 5;
    localparam logic [BITCNT_W-1:0] BITCNT_MAX = 5'd31;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

endpackage

// File: rtl/audio_rr_pick.sv
// Round-robin picker: first set candidate searching upward (mod NREQ)
// from the position just after ptr_i.
module audio_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         cand_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic                    valid_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic [NREQ-1:0]         onehot_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] pos;

    // Scan farthest-first so the nearest candidate after ptr_i is the last one written.
    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        pos      = '0;
        onehot_o = '0;
        for (int i = NREQ; i >= 1; i--) begin
            pos = IW'((int'(ptr_i) + i) % NREQ);
            if (cand_i[pos]) begin
                valid_o = 1'b1;
                idx_o   = pos;
            end
        end
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/audio_dac_slot_arbiter.sv
// Shares the two I2S DAC slots between NREQ requesters, round-robin per
// channel, arbitrating each slot one slot ahead and serialising MSB first.
module audio_dac_slot_arbiter
    import audio_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ARB_BIT   = 8,
    parameter int HOLD_LAST = 0
) (
    input  logic                     BCLK,
    input  logic                     iRST_N,
    input  logic                     iLRCK,
    input  logic                     iENABLE,
    input  logic [NREQ-1:0]          iREQ,
    input  logic [NREQ-1:0]          iREQ_CH,
    input  logic [NREQ*SAMPLE_W-1:0] iSAMPLE,
    output logic [NREQ-1:0]          oGNT,
    output logic                     oDACDAT,
    output logic                     oLOCK,
    output logic                     oMISS
);

    localparam int IW = $clog2(NREQ);

    // Valid/ready note: iREQ is the requester's valid, held until a one-cycle
    // oGNT pulse; the sample is taken in the cycle before oGNT goes high.

    state_e                state_q, state_d;
    logic                  lrck_q;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [SAMPLE_W-1:0]   shreg_q, shreg_d;
    logic                  dacdat_q, dacdat_d;
    logic                  miss_q, miss_d;
    logic                  arb_done_q, arb_done_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [SAMPLE_W-1:0]   pending_q [2];
    logic [SAMPLE_W-1:0]   pending_d [2];
    logic [IW-1:0]         rr_ptr_q [2];
    logic [IW-1:0]         rr_ptr_d [2];

    logic                  lrck_edge;
    logic                  nc;
    logic                  ch;
    logic [NREQ-1:0]       cand;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [NREQ-1:0]       pick_onehot;
    logic [SAMPLE_W-1:0]   samples [NREQ];

    assign lrck_edge = iLRCK ^ lrck_q;
    assign ch        = iLRCK;
    assign nc        = ~lrck_q;
    assign cand      = iENABLE ? (iREQ & ~(iREQ_CH ^ {NREQ{nc}})) : '0;

    // Unpack the flat sample bus into one word per requester.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            samples[k] = iSAMPLE[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    audio_rr_pick #(.NREQ(NREQ)) u_pick (
        .cand_i   (cand),
        .ptr_i    (rr_ptr_q[nc]),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // Next-state: lock FSM, slot start, serialiser and next-slot arbitration.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        dacdat_d   = dacdat_q;
        miss_d     = 1'b0;
        arb_done_d = arb_done_q;
        gnt_d      = '0;
        pending_d  = pending_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            ST_UNLOCKED: begin
                bitcnt_d = '0;
                dacdat_d = 1'b0;
                if (lrck_edge) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (lrck_edge) begin
                    // Slot start: MSB leaves one BCLK after the LRCK edge.
                    shreg_d    = pending_q[ch] << 1;
                    dacdat_d   = pending_q[ch][SAMPLE_W-1];
                    bitcnt_d   = BITCNT_W'(1);
                    miss_d     = ~arb_done_q;
                    arb_done_d = 1'b0;
                end else begin
                    if (bitcnt_q != BITCNT_MAX) begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                    if (bitcnt_q <= BITCNT_W'(SAMPLE_W - 1)) begin
                        dacdat_d = shreg_q[SAMPLE_W-1];
                        shreg_d  = shreg_q << 1;
                    end else begin
                        dacdat_d = 1'b0;
                    end
                    if (bitcnt_q == BITCNT_W'(ARB_BIT)) begin
                        arb_done_d = 1'b1;
                        if (pick_valid) begin
                            pending_d[nc] = samples[pick_idx];
                            rr_ptr_d[nc]  = pick_idx;
                            gnt_d         = pick_onehot;
                        end else if (HOLD_LAST == 0 || !iENABLE) begin
                            pending_d[nc] = SILENCE;
                        end
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge BCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= ST_UNLOCKED;
            lrck_q       <= 1'b0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            dacdat_q     <= 1'b0;
            miss_q       <= 1'b0;
            arb_done_q   <= 1'b0;
            gnt_q        <= '0;
            pending_q[0] <= SILENCE;
            pending_q[1] <= SILENCE;
            rr_ptr_q[0]  <= IW'(NREQ - 1);
            rr_ptr_q[1]  <= IW'(NREQ - 1);
        end else begin
            state_q    <= state_d;
            lrck_q     <= iLRCK;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            dacdat_q   <= dacdat_d;
            miss_q     <= miss_d;
            arb_done_q <= arb_done_d;
            gnt_q      <= gnt_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign oGNT    = gnt_q;
    assign oDACDAT = dacdat_q;
    assign oMISS   = miss_q;
    assign oLOCK   = (state_q == ST_LOCKED);

endmodule
